// File: rtl/demultiplexor_registrado.sv
// demultiplexor_registrado: registered 1-to-2 demultiplexer.
// Each input word is steered by demux_sel into one of two single-entry output
// buffers. Each buffer drains over its own valid/ready handshake.
// Ready passes through combinationally: a full lane whose consumer is
// accepting in the same cycle can also take a new word in that cycle.
// Optional feature: define DEMUX_CONTADORES_EN to add the per-lane 16-bit
// output-transfer counters cont1/cont2.
module demultiplexor_registrado #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] entrada_demux,
  input  logic             entrada_valida,
  output logic             entrada_lista,
  input  logic             demux_sel,
  output logic [ANCHO-1:0] salida1_demux,
  output logic             salida1_valida,
  input  logic             salida1_lista,
  output logic [ANCHO-1:0] salida2_demux,
  output logic             salida2_valida,
  input  logic             salida2_lista
`ifdef DEMUX_CONTADORES_EN
  ,
  output logic [15:0]      cont1,
  output logic [15:0]      cont2
`endif
);

  typedef enum logic {VACIO = 1'b0, LLENO = 1'b1} estado_t;

  // Lane index 0 is lane 1 (demux_sel=1), index 1 is lane 2 (demux_sel=0).
  logic [1:0]       lane_lista;
  logic [1:0]       lane_acepta;
  logic [1:0]       lane_carga;
  logic [1:0]       lane_valida;
  logic [ANCHO-1:0] lane_dato [2];
  logic             entrada_fire;

  assign lane_lista = {salida2_lista, salida1_lista};

  // Ready depends only on the selected lane's state and its consumer ready,
  // never on entrada_valida.
  assign entrada_lista = demux_sel ? lane_acepta[0] : lane_acepta[1];
  assign entrada_fire  = entrada_valida & entrada_lista;
  assign lane_carga    = {entrada_fire & ~demux_sel, entrada_fire & demux_sel};

`ifdef DEMUX_CONTADORES_EN
  logic [15:0] lane_cont [2];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_carril
      estado_t          estado_q, estado_d;
      logic [ANCHO-1:0] dato_q, dato_d;
      logic             salida_fire;
      logic             valida;

      assign salida_fire     = (estado_q == LLENO) & lane_lista[gi];
      assign lane_acepta[gi] = (estado_q == VACIO) | lane_lista[gi];

      // State and data registers; reset empties the lane and clears its data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          estado_q <= VACIO;
          dato_q   <= '0;
        end else begin
          estado_q <= estado_d;
          dato_q   <= dato_d;
        end
      end

      // Next state: fill on input fire, empty on a drain without refill.
      always_comb begin
        estado_d = estado_q;
        dato_d   = dato_q;
        if (lane_carga[gi]) begin
          dato_d = entrada_demux;
        end
        case (estado_q)
          VACIO: if (lane_carga[gi]) estado_d = LLENO;
          LLENO: if (salida_fire && !lane_carga[gi]) estado_d = VACIO;
          default: estado_d = VACIO;
        endcase
      end

      // Output decode: the lane presents valid exactly while it is full.
      always_comb begin
        valida = (estado_q == LLENO);
      end

      assign lane_valida[gi] = valida;
      assign lane_dato[gi]   = dato_q;

`ifdef DEMUX_CONTADORES_EN
      logic [15:0] cont_q, cont_d;

      // Transfer counter register; wraps naturally at 16 bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cont_q <= '0;
        end else begin
          cont_q <= cont_d;
        end
      end

      // Count one per completed output handshake.
      always_comb begin
        cont_d = cont_q;
        if (salida_fire) cont_d = cont_q + 16'd1;
      end

      assign lane_cont[gi] = cont_q;
`endif
    end
  endgenerate

  assign salida1_demux  = lane_dato[0];
  assign salida1_valida = lane_valida[0];
  assign salida2_demux  = lane_dato[1];
  assign salida2_valida = lane_valida[1];

`ifdef DEMUX_CONTADORES_EN
  assign cont1 = lane_cont[0];
  assign cont2 = lane_cont[1];
`endif

endmodule
